// File: rtl/video2ram_f_if.sv
// video2ram_f_if: decoded pixel stream in, ring-buffer write port out.
interface video2ram_f_if;
  logic [23:0] in_pixel;
  logic        in_valid;
  logic        in_line_start;
  logic        in_frame_start;
  logic [13:0] wraddr;
  logic [23:0] wrdata;
  logic        wren;
  modport master (output in_pixel, in_valid, in_line_start, in_frame_start,
                  input wraddr, wrdata, wren);
  modport slave (input in_pixel, in_valid, in_line_start, in_frame_start,
                 output wraddr, wrdata, wren);
endinterface

// File: rtl/video2ram_f.sv
// video2ram_f: crops the decoded pixel stream into the shared line ring buffer.
module video2ram_f #(
  parameter int BUFFER_LINE_LENGTH = 640,
  parameter int RAM_NUMWORDS       = 14720,
  parameter int CAPTURE_X_START    = 0,
  parameter int CAPTURE_Y_START    = 0,
  parameter int CAPTURE_LINES      = 480,
  parameter int TRIGGER_LINES      = 2
) (
  input  logic         clock,
  input  logic         reset,
  video2ram_f_if.slave bus,
  output logic         starttrigger,
  output logic         capture_active,
  output logic         overrun
);
  typedef enum logic [1:0] {IDLE, WAIT_LINE, CAPTURE, FRAME_DONE} state_t;
  localparam logic [10:0] X_LO    = 11'(CAPTURE_X_START);
  localparam logic [10:0] X_LEN   = 11'(BUFFER_LINE_LENGTH);
  localparam logic [10:0] Y_LO    = 11'(CAPTURE_Y_START);
  localparam logic [10:0] N_LINES = 11'(CAPTURE_LINES);
  localparam logic [10:0] N_TRIG  = 11'(TRIGGER_LINES);
  localparam logic [13:0] B_STEP  = 14'(BUFFER_LINE_LENGTH);
  localparam logic [13:0] B_LIM   = 14'(RAM_NUMWORDS - BUFFER_LINE_LENGTH);
  function automatic logic [13:0] next_base(input logic [13:0] b);
    return (b < B_LIM) ? b + B_STEP : '0;
  endfunction
  state_t      state, st1, state_n;
  logic [10:0] raw_y, raw1, cap_y, cap1, x, x1;
  logic [11:0] xr, yr;
  logic [13:0] base, base1;
  logic [1:0]  frames;
  logic        ovr, hit, last;
  // Line/frame starts are resolved first so a pixel arriving with them is index 0 of the new line.
  always_comb begin
    st1   = state;
    raw1  = raw_y;
    cap1  = cap_y;
    base1 = base;
    x1    = x;
    ovr   = 1'b0;
    yr    = '0;
    if (bus.in_frame_start) begin
      raw1  = '0;
      cap1  = '0;
      base1 = '0;
      x1    = '0;
      st1   = (Y_LO == '0) ? CAPTURE : WAIT_LINE;
    end else if (bus.in_line_start && (state == WAIT_LINE || state == CAPTURE)) begin
      raw1  = (raw_y == '1) ? raw_y : raw_y + 11'd1;
      x1    = '0;
      ovr   = (state == CAPTURE);
      cap1  = cap_y + {10'd0, ovr};
      base1 = ovr ? next_base(base) : base;
      yr    = {1'b0, raw1} - {1'b0, Y_LO};
      st1   = (cap1 >= N_LINES) ? FRAME_DONE : !yr[11] ? CAPTURE : WAIT_LINE;
    end
    xr      = {1'b0, x1} - {1'b0, X_LO};
    hit     = bus.in_valid && st1 == CAPTURE && !xr[11] && xr[10:0] < X_LEN;
    last    = hit && xr[10:0] == X_LEN - 11'd1;
    state_n = last ? ((cap1 + 11'd1 >= N_LINES) ? FRAME_DONE : WAIT_LINE) : st1;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      raw_y        <= '0;
      cap_y        <= '0;
      base         <= '0;
      x            <= '0;
      frames       <= '0;
      starttrigger <= 1'b0;
      overrun      <= 1'b0;
      bus.wren     <= 1'b0;
      bus.wraddr   <= '0;
      bus.wrdata   <= '0;
    end else begin
      raw_y        <= raw1;
      cap_y        <= cap1 + {10'd0, last};
      base         <= last ? next_base(base1) : base1;
      x            <= (bus.in_valid && x1 != '1) ? x1 + 11'd1 : x1;
      frames       <= (bus.in_frame_start && frames != 2'd2) ? frames + 2'd1 : frames;
      starttrigger <= starttrigger | (frames == 2'd1 && cap_y >= N_TRIG);
      overrun      <= ovr;
      bus.wren     <= hit;
      if (hit) begin
        bus.wraddr <= base1 + {3'd0, xr[10:0]};
        bus.wrdata <= bus.in_pixel;
      end
    end
  assign capture_active = (state == CAPTURE);
endmodule

// File: tb/tb_video2ram_f.sv
// tb_video2ram_f: two configurations checked against a line/pixel-count reference model.
module tb_video2ram_f;
  localparam int LEN = 640, RAM = 14720, TRIG = 2;
  logic clock = 1'b0, reset = 1'b0;
  always #5 clock = ~clock;
  video2ram_f_if bus0 (), bus1 ();
  logic [1:0] trig, act, ov;
  video2ram_f u0 (.clock(clock), .reset(reset), .bus(bus0), .starttrigger(trig[0]),
                  .capture_active(act[0]), .overrun(ov[0]));
  video2ram_f #(.CAPTURE_X_START(8), .CAPTURE_Y_START(2), .CAPTURE_LINES(4)) u1 (
    .clock(clock), .reset(reset), .bus(bus1), .starttrigger(trig[1]),
    .capture_active(act[1]), .overrun(ov[1]));
  int xs[2] = '{0, 8};
  int ys[2] = '{0, 2};
  int lines[2] = '{480, 4};
  int m_frames[2], m_raw[2], m_done[2], m_idx[2];
  bit m_cap[2], m_trig[2];
  bit e_wr[2], e_ov[2], e_cap[2], e_trig[2];
  int e_addr[2];
  logic [23:0] e_data[2];
  int n_tests = 0, n_fail = 0;
  int n_wr[2], n_ov[2];
  int first_addr0 = -1;
  logic prev_w0 = 1'b0;
  typedef struct { bit fs; int npix; int wr0; int wr1; int ov0; int ov1; } vec_t;
  vec_t tbl[8];
  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_frames[d] = 0; m_raw[d] = 0; m_done[d] = 0; m_idx[d] = 0;
      m_cap[d] = 0; m_trig[d] = 0;
    end
  endfunction
  // Lines written so far decide the ring slot; pixel index decides the word within it.
  function automatic void model_step(int d, bit fs, bit ls, bit v, logic [23:0] px);
    int rel;
    bit in_frame;
    e_trig[d] = m_trig[d] || (m_frames[d] == 1 && m_done[d] >= TRIG);
    m_trig[d] = e_trig[d];
    e_wr[d] = 0; e_ov[d] = 0; e_addr[d] = 0; e_data[d] = '0;
    in_frame = m_frames[d] > 0 && m_done[d] < lines[d];
    if (fs) begin
      m_frames[d] = (m_frames[d] < 2) ? m_frames[d] + 1 : 2;
      m_raw[d] = 0; m_done[d] = 0; m_idx[d] = 0; m_cap[d] = (ys[d] == 0);
    end else if (ls && in_frame) begin
      if (m_cap[d]) begin e_ov[d] = 1; m_done[d]++; end
      m_raw[d]++;
      m_idx[d] = 0;
      m_cap[d] = m_done[d] < lines[d] && m_raw[d] >= ys[d];
    end
    if (v) begin
      rel = m_idx[d] - xs[d];
      if (m_cap[d] && rel >= 0 && rel < LEN) begin
        e_wr[d] = 1;
        e_addr[d] = (m_done[d] * LEN) % RAM + rel;
        e_data[d] = px;
        if (rel == LEN - 1) begin m_done[d]++; m_cap[d] = 0; end
      end
      if (m_idx[d] < 2047) m_idx[d]++;
    end
    e_cap[d] = m_cap[d];
  endfunction
  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask
  task automatic check_cycle(int d);
    logic w, o, c, t;
    logic [13:0] a;
    logic [23:0] dt;
    bit ok;
    w = d ? bus1.wren : bus0.wren;
    a = d ? bus1.wraddr : bus0.wraddr;
    dt = d ? bus1.wrdata : bus0.wrdata;
    o = ov[d]; c = act[d]; t = trig[d];
    n_tests++;
    ok = w == e_wr[d] && o == e_ov[d] && c == e_cap[d] && t == e_trig[d] &&
         (!e_wr[d] || (a == 14'(e_addr[d]) && dt == e_data[d]));
    if (!ok) begin
      n_fail++;
      $display("FAIL cycle dut%0d t=%0t: got wren=%b addr=%0d data=%0h ovr=%b act=%b trig=%b, want wren=%b addr=%0d data=%0h ovr=%b act=%b trig=%b",
               d, $time, w, a, dt, o, c, t, e_wr[d], e_addr[d], e_data[d], e_ov[d], e_cap[d], e_trig[d]);
    end
    n_wr[d] += int'(w);
    n_ov[d] += int'(o);
    if (d == 0) begin
      if (w && !prev_w0) first_addr0 = int'(a);
      prev_w0 = w;
    end
  endtask
  task automatic drive(bit fs, bit ls, bit v, logic [23:0] px);
    bus0.in_frame_start = fs; bus0.in_line_start = ls; bus0.in_valid = v; bus0.in_pixel = px;
    bus1.in_frame_start = fs; bus1.in_line_start = ls; bus1.in_valid = v; bus1.in_pixel = px;
  endtask
  task automatic cyc(bit fs, bit ls, bit v, logic [23:0] px);
    drive(fs, ls, v, px);
    @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      model_step(d, fs, ls, v, px);
      check_cycle(d);
    end
  endtask
  task automatic line(bit fs, int npix, int gap);
    cyc(fs, !fs, 1'b0, '0);
    for (int i = 0; i < npix; i++) cyc(1'b0, 1'b0, 1'b1, 24'(i));
    repeat (gap) cyc(1'b0, 1'b0, 1'b0, '0);
  endtask
  initial begin
    bit fs;
    int n, cnt;
    bit v;
    tbl[0] = '{1, 640, 640, 0, 0, 0};
    tbl[1] = '{0, 640, 640, 0, 0, 0};
    tbl[2] = '{0, 700, 640, 640, 0, 0};
    tbl[3] = '{0, 700, 640, 640, 0, 0};
    tbl[4] = '{0, 300, 300, 292, 0, 0};
    tbl[5] = '{0, 640, 640, 632, 1, 1};
    tbl[6] = '{0, 300, 300, 0, 0, 1};
    tbl[7] = '{1, 640, 640, 0, 0, 0};
    drive(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom));
      @(posedge clock);
      #1;
      check("reset_outputs", 64'({bus0.wren, bus0.wraddr, bus1.wren, bus1.wraddr, trig, act, ov}), 64'd0);
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) cyc(1'b0, i % 7 == 0, 1'b1, 24'($urandom));
    check("idle_no_write", 64'({act, trig}), 64'd0);
    for (int k = 0; k < 8; k++) begin
      n_wr = '{0, 0};
      n_ov = '{0, 0};
      line(tbl[k].fs, tbl[k].npix, 3);
      check($sformatf("vec%0d_writes0", k), 64'(n_wr[0]), 64'(tbl[k].wr0));
      check($sformatf("vec%0d_writes1", k), 64'(n_wr[1]), 64'(tbl[k].wr1));
      check($sformatf("vec%0d_overrun0", k), 64'(n_ov[0]), 64'(tbl[k].ov0));
      check($sformatf("vec%0d_overrun1", k), 64'(n_ov[1]), 64'(tbl[k].ov1));
      if (k == 1) check("trigger_after_two_lines", 64'(trig), 64'b01);
    end
    check("trigger_sticky", 64'(trig), 64'b11);
    line(1'b1, 640, 2);
    for (int k = 1; k < 24; k++) begin
      line(1'b0, 640, 2);
      if (k == 22) check("line23_base", 64'(first_addr0), 64'd14080);
      if (k == 23) check("line24_wrap", 64'(first_addr0), 64'd0);
    end
    cyc(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, 1'b1, 24'($urandom));
    check("midline_wren_before_reset", 64'(bus0.wren), 64'd1);
    reset = 1'b0;
    #1;
    check("async_reset_outputs", 64'({bus0.wren, bus1.wren, trig, ov}), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0, 1'b1, 24'($urandom));
    for (int l = 0; l < 14; l++) begin
      fs = (l == 0) || ($urandom % 5 == 0);
      n = $urandom_range(720, 560);
      v = 1'($urandom);
      cyc(fs, !fs, v, 24'($urandom));
      cnt = int'(v);
      while (cnt < n) begin
        v = ($urandom % 4) != 0;
        cyc(1'b0, 1'b0, v, 24'($urandom));
        cnt += int'(v);
      end
    end
    repeat (3) cyc(1'b0, 1'b0, 1'b0, '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
